divider_6by3_seq: RTL and testbench

- Sequential restoring divider: the inverse operation of the team's 3x3 array multiplier.
- Takes a 2N-bit dividend (product width) and an N-bit divisor; returns a 2N-bit quotient and an N-bit remainder.
- Retires one quotient bit per clock, with a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic block set; its results are checked against it (q*d + r == dividend).

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_restoring_step.sv | 37 +++
 rtl/divider_6by3_seq.sv | 128 ++++++++++++
 tb/tb_divider_6by3_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   state_e          : controller state encoding (IDLE / RUN / DONE)
//   DIV_N            : default operand width
//   DIV_ZERO_Q_FILL  : bit value replicated across the quotient on a zero divisor
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DIV_N = 3;

    // A zero divisor reports a quotient with every bit set.
    localparam logic DIV_ZERO_Q_FILL = 1'b1;

endpackage

// File: rtl/div_restoring_step.sv
// -----------------------------------------------------------------------------
// div_restoring_step
// One combinational iteration of restoring division.
//   pr_i       [N:0]   partial remainder before the shift
//   qs_msb_i           next dividend bit shifted into the partial remainder
//   divisor_i  [N-1:0] divisor
//   pr_next_o  [N:0]   partial remainder after the trial subtraction
//   q_bit_o            quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_restoring_step #(
    parameter int N = 3
) (
    input  logic [N:0]   pr_i,
    input  logic         qs_msb_i,
    input  logic [N-1:0] divisor_i,
    output logic [N:0]   pr_next_o,
    output logic         q_bit_o
);

    // Shifted remainder is kept at N+2 bits so the subtraction has a sign bit.
    // pr_i[N] is always 0 between steps, so the top bit is 0 as well.
    logic signed [N+1:0] pr_shift;
    logic signed [N+1:0] trial;

    always_comb begin
        pr_shift = {pr_i, qs_msb_i};
        trial    = pr_shift - $signed({2'b00, divisor_i});
        if (trial >= 0) begin
            pr_next_o = trial[N:0];
            q_bit_o   = 1'b1;
        end else begin
            pr_next_o = pr_shift[N:0];
            q_bit_o   = 1'b0;
        end
    end

endmodule

// File: rtl/divider_6by3_seq.sv
// -----------------------------------------------------------------------------
// divider_6by3_seq
// Sequential restoring divider, one quotient bit per clock.
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request a division (accepted only when not busy)
//   in1  [2N-1:0] dividend, captured on an accepted start
//   in2  [N-1:0]  divisor, captured on an accepted start
//   q    [2N-1:0] quotient (registered, holds while busy)
//   r    [N-1:0]  remainder (registered, holds while busy)
//   busy         iterating
//   done         q/r valid; held until the next accepted start
//   div_by_zero  zero-divisor flag, valid while done
// -----------------------------------------------------------------------------
module divider_6by3_seq
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] in1,
    input  logic [N-1:0]   in2,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero
);

    localparam int CNT_W = $clog2(2*N + 1);

    state_e           state_q, state_d;
    logic [N:0]       pr_q, pr_d;
    logic [2*N-1:0]   qs_q, qs_d;
    logic [N-1:0]     dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   q_q, q_d;
    logic [N-1:0]     r_q, r_d;
    logic             dz_q, dz_d;

    logic [N:0]       step_pr;
    logic             step_bit;

    div_restoring_step #(.N(N)) u_step (
        .pr_i      (pr_q),
        .qs_msb_i  (qs_q[2*N-1]),
        .divisor_i (dvs_q),
        .pr_next_o (step_pr),
        .q_bit_o   (step_bit)
    );

    always_comb begin
        state_d = state_q;
        pr_d    = pr_q;
        qs_d    = qs_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (in2 == '0) begin
                        // Zero divisor resolves in the accepting edge.
                        state_d = ST_DONE;
                        q_d     = {(2*N){DIV_ZERO_Q_FILL}};
                        r_d     = '0;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        pr_d    = '0;
                        qs_d    = in1;
                        dvs_d   = in2;
                        cnt_d   = CNT_W'(2*N);
                        dz_d    = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                // Quotient bits fill qs from the bottom as dividend bits leave the top.
                pr_d  = step_pr;
                qs_d  = {qs_q[2*N-2:0], step_bit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    q_d     = {qs_q[2*N-2:0], step_bit};
                    r_d     = step_pr[N-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and visible result registers: reset has priority over start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    // Working datapath registers: only meaningful while in RUN.
    always_ff @(posedge clk) begin
        pr_q  <= pr_d;
        qs_q  <= qs_d;
        dvs_q <= dvs_d;
    end

    assign q           = q_q;
    assign r           = r_q;
    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_divider_6by3_seq.sv
module tb_divider_6by3_seq;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] in1;
    logic [N-1:0]   in2;
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           busy;
    logic           done;
    logic           div_by_zero;

    always #5 clk = ~clk;

    divider_6by3_seq #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in1         (in1),
        .in2         (in2),
        .q           (q),
        .r           (r),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] a;
        logic [2:0] d;
        int         q;
        int         r;
        int         dz;
        int         lat;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division, with the zero-divisor convention.
    function automatic void model(input int a, input int d,
                                  output int eq, output int er, output int edz);
        if (d == 0) begin
            eq = 63; er = 0; edz = 1;
        end else begin
            eq = a / d; er = a % d; edz = 0;
        end
    endfunction

    // Single-shot transaction: one-edge start pulse, then wait (bounded) for done.
    task automatic run_div(input logic [5:0] a, input logic [2:0] d,
                           input int eq, input int er, input int edz, input int elat,
                           input string tag);
        int lat;
        in1 = a; in2 = d; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, (elat != 0));
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_q"}, q, eq);
        chk({tag, "_r"}, r, er);
        chk({tag, "_dz"}, div_by_zero, edz);
        chk({tag, "_busy_at_done"}, busy, 0);
    endtask

    initial begin
        int lat;
        int eq, er, edz;
        logic [5:0] q_hold;
        logic [5:0] ra;
        logic [2:0] rd;

        tbl[0] = '{a: 6'd36, d: 3'd5, q: 7,  r: 1, dz: 0, lat: 6};
        tbl[1] = '{a: 6'd63, d: 3'd1, q: 63, r: 0, dz: 0, lat: 6};
        tbl[2] = '{a: 6'd0,  d: 3'd3, q: 0,  r: 0, dz: 0, lat: 6};
        tbl[3] = '{a: 6'd49, d: 3'd7, q: 7,  r: 0, dz: 0, lat: 6};
        tbl[4] = '{a: 6'd42, d: 3'd0, q: 63, r: 0, dz: 1, lat: 0};

        // Reset state
        rst_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("reset_q", q, 0);
        chk("reset_r", r, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_dz", div_by_zero, 0);

        // Directed table
        for (int i = 0; i < 5; i++)
            run_div(tbl[i].a, tbl[i].d, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat,
                    $sformatf("tbl%0d", i));

        // Result holds while idle in DONE
        tick(); tick();
        chk("hold_done", done, 1);
        chk("hold_q", q, 63);

        // Start while busy is ignored; outputs hold their previous values
        q_hold = q;
        in1 = 6'd36; in2 = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        tick(); lat++;
        in1 = 6'd10; in2 = 3'd2; start = 1'b1;
        tick(); lat++;
        start = 1'b0;
        chk("ign_busy", busy, 1);
        chk("ign_q_hold", q, q_hold);
        chk("ign_done_low", done, 0);
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        chk("ign_latency", lat, 6);
        chk("ign_q", q, 7);
        chk("ign_r", r, 1);
        tick();
        chk("ign_no_restart", busy, 0);

        // Reset mid-run, with start high at the reset edge
        in1 = 6'd45; in2 = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0; start = 1'b1;
        tick();
        chk("rstrun_q", q, 0);
        chk("rstrun_r", r, 0);
        chk("rstrun_busy", busy, 0);
        chk("rstrun_done", done, 0);
        chk("rstrun_dz", div_by_zero, 0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        chk("rstrun_idle_busy", busy, 0);
        chk("rstrun_idle_done", done, 0);
        run_div(6'd45, 3'd4, 11, 1, 0, 6, "post_rst");

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = 6'($urandom_range(0, 63));
            rd = 3'($urandom_range(0, 7));
            model(int'(ra), int'(rd), eq, er, edz);
            run_div(ra, rd, eq, er, edz, (rd == 0) ? 0 : 6, $sformatf("rnd%0d", i));
        end

        // Exhaustive sweep, start held high: each completion restarts immediately
        start = 1'b1;
        for (int a = 0; a < 64; a++) begin
            for (int d = 0; d < 8; d++) begin
                in1 = 6'(a); in2 = 3'(d);
                tick();
                if (d != 0) chk($sformatf("sw_done_drop_%0d_%0d", a, d), done, 0);
                lat = 0;
                while (!done && lat < 20) begin
                    tick();
                    lat++;
                end
                chk($sformatf("sw_lat_%0d_%0d", a, d), lat, (d == 0) ? 0 : 6);
                if (d == 0) begin
                    chk($sformatf("sw_dz_%0d", a), div_by_zero, 1);
                end else begin
                    chk($sformatf("sw_recon_%0d_%0d", a, d), int'(q) * d + int'(r), a);
                    chk($sformatf("sw_rlt_%0d_%0d", a, d), (int'(r) < d), 1);
                    chk($sformatf("sw_dz0_%0d_%0d", a, d), div_by_zero, 0);
                end
            end
        end
        start = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
